// File: rtl/fanout_pipe.sv
// Delay pipeline with a capture register, a DEPTH-stage valid-tracked chain, a selectable bypass
// path, per-channel broadcast registers and drain sequencing when the delay mode changes.
//
// state | meaning
// RUN   | accepting input; a mode change is applied directly when the pipe is empty
// DRAIN | mode change pending; input blocked until every in-flight word has left

module fanout_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 5,
  parameter int NCH   = 11
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH-1:0]            in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  input  logic [NCH-1:0]              ch_en,
  output logic [NCH*WIDTH-1:0]        ch_data,
  output logic [NCH-1:0]              ch_valid,
  input  logic                        bypass,
  input  logic                        flush,
  output logic [$clog2(DEPTH+2)-1:0]  occupancy,
  output logic [15:0]                 cap_count
);

  localparam int OW = $clog2(DEPTH+2);
  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]       state;
  logic             active_mode;
  logic             cap_valid;
  logic [WIDTH-1:0] cap_data;
  logic [DEPTH:1]   chain_valid;
  logic [WIDTH-1:0] chain_data [1:DEPTH];
  logic [WIDTH-1:0] hold_data;
  logic [WIDTH-1:0] sel_data;
  logic             stall;
  logic             accept;
  logic             xfer;
  logic             to_chain;

  assign out_valid = active_mode ? cap_valid : chain_valid[DEPTH];
  assign sel_data  = active_mode ? cap_data : chain_data[DEPTH];
  // out_data is held by a shadow register so it never moves while out_valid is low
  assign out_data  = out_valid ? sel_data : hold_data;
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall && !flush && (state == RUN);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign to_chain  = cap_valid && !active_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid   <= 1'b0;
      cap_data    <= '0;
      chain_valid <= '0;
      for (int i = 1; i <= DEPTH; i++) chain_data[i] <= '0;
    end else if (flush) begin
      cap_valid   <= 1'b0;
      chain_valid <= '0;
    end else if (!stall) begin
      cap_valid <= accept;
      if (accept) cap_data <= in_data;
      chain_valid[1] <= to_chain;
      if (to_chain) chain_data[1] <= cap_data;
      for (int i = 2; i <= DEPTH; i++) begin
        chain_valid[i] <= chain_valid[i-1];
        if (chain_valid[i-1]) chain_data[i] <= chain_data[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         hold_data <= '0;
    else if (out_valid) hold_data <= sel_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (accept && !xfer) begin
      occupancy <= occupancy + OW'(1);
    end else if (!accept && xfer) begin
      occupancy <= occupancy - OW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cap_count <= '0;
    else if (accept) cap_count <= cap_count + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_data  <= '0;
      ch_valid <= '0;
    end else begin
      ch_valid <= accept ? ch_en : '0;
      for (int i = 0; i < NCH; i++) begin
        if (accept && ch_en[i]) ch_data[i*WIDTH +: WIDTH] <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      active_mode <= 1'b0;
    end else if (flush) begin
      state       <= RUN;
      active_mode <= bypass;
    end else begin
      case (state)
        RUN: begin
          if (bypass != active_mode) begin
            if (occupancy == '0) active_mode <= bypass;
            else                 state       <= DRAIN;
          end
        end
        DRAIN: begin
          if (occupancy == '0) begin
            active_mode <= bypass;
            state       <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fanout_pipe.sv
// Directed bench for fanout_pipe (WIDTH=8, DEPTH=5, NCH=3): a per-cycle vector table followed by
// hand sequences for stall, mode drain, flush, cap_count wrap and mid-stream reset.
module tb_fanout_pipe;
  localparam int W  = 8;
  localparam int D  = 5;
  localparam int N  = 3;
  localparam int OW = $clog2(D+2);

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   ch_en;
  logic [N*W-1:0] ch_data;
  logic [N-1:0]   ch_valid;
  logic           bypass;
  logic           flush;
  logic [OW-1:0]  occupancy;
  logic [15:0]    cap_count;

  fanout_pipe #(.WIDTH(W), .DEPTH(D), .NCH(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ch_en(ch_en), .ch_data(ch_data), .ch_valid(ch_valid),
    .bypass(bypass), .flush(flush),
    .occupancy(occupancy), .cap_count(cap_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // inputs for one cycle, in_ready expected during it, registered outputs expected after its edge
  typedef struct {
    logic         iv;
    logic [7:0]   id;
    logic [2:0]   en;
    logic         byp;
    logic         e_ir;
    logic         e_ov;
    logic [7:0]   e_od;
    logic [2:0]   e_occ;
    logic [2:0]   e_chv;
    logic [23:0]  e_chd;
  } vec_t;

  function automatic vec_t mk(logic iv, logic [7:0] id, logic [2:0] en, logic byp, logic e_ir,
                              logic e_ov, logic [7:0] e_od, logic [2:0] e_occ, logic [2:0] e_chv,
                              logic [23:0] e_chd);
    vec_t v;
    v.iv = iv; v.id = id; v.en = en; v.byp = byp; v.e_ir = e_ir;
    v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ; v.e_chv = e_chv; v.e_chd = e_chd;
    return v;
  endfunction

  vec_t tbl [20];

  int e_ir37  [11] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1};
  int e_ov37  [11] = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1};
  int e_od37  [11] = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h21, 8'h22, 8'h23, 8'h23, 8'h23, 8'h44};
  int e_occ37 [11] = '{1, 2, 3, 3, 3, 3, 2, 1, 0, 0, 1};

  initial begin
    int exp_cap;
    int got;
    int nw;
    logic acc;

    tbl[0]  = mk(1, 8'h0A, 3'b000, 0, 1, 0, 8'h00, 1, 3'b000, 24'h000000);
    tbl[1]  = mk(0, 8'h00, 3'b000, 0, 1, 0, 8'h00, 1, 3'b000, 24'h000000);
    tbl[2]  = tbl[1];
    tbl[3]  = tbl[1];
    tbl[4]  = tbl[1];
    tbl[5]  = mk(0, 8'h00, 3'b000, 0, 1, 1, 8'h0A, 1, 3'b000, 24'h000000);
    tbl[6]  = mk(0, 8'h00, 3'b000, 0, 1, 0, 8'h0A, 0, 3'b000, 24'h000000);
    tbl[7]  = tbl[6];
    tbl[8]  = mk(1, 8'h33, 3'b010, 0, 1, 0, 8'h0A, 1, 3'b010, 24'h003300);
    tbl[9]  = mk(1, 8'h05, 3'b101, 0, 1, 0, 8'h0A, 2, 3'b101, 24'h053305);
    tbl[10] = mk(0, 8'h00, 3'b101, 0, 1, 0, 8'h0A, 2, 3'b000, 24'h053305);
    tbl[11] = mk(0, 8'h00, 3'b000, 0, 1, 0, 8'h0A, 2, 3'b000, 24'h053305);
    tbl[12] = tbl[11];
    tbl[13] = mk(0, 8'h00, 3'b000, 0, 1, 1, 8'h33, 2, 3'b000, 24'h053305);
    tbl[14] = mk(0, 8'h00, 3'b000, 0, 1, 1, 8'h05, 1, 3'b000, 24'h053305);
    tbl[15] = mk(0, 8'h00, 3'b000, 0, 1, 0, 8'h05, 0, 3'b000, 24'h053305);
    tbl[16] = mk(0, 8'h00, 3'b000, 1, 1, 0, 8'h05, 0, 3'b000, 24'h053305);
    tbl[17] = mk(1, 8'h77, 3'b000, 1, 1, 1, 8'h77, 1, 3'b000, 24'h053305);
    tbl[18] = mk(0, 8'h00, 3'b000, 1, 1, 0, 8'h77, 0, 3'b000, 24'h053305);
    tbl[19] = mk(0, 8'h00, 3'b000, 0, 1, 0, 8'h77, 0, 3'b000, 24'h053305);

    rst_n = 1'b1; in_data = '0; in_valid = 0; out_ready = 1; ch_en = '0; bypass = 0; flush = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_cap_count", cap_count, 0);
    chk("rst_ch_valid", ch_valid, 0);
    chk("rst_ch_data", ch_data, 0);
    chk("rst_in_ready", in_ready, 1);
    #9 rst_n = 1'b1;

    // table: chain latency, channel broadcast, bypass latency
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = tbl[i].iv; in_data = tbl[i].id; ch_en = tbl[i].en; bypass = tbl[i].byp;
      #1;
      chk($sformatf("v%0d_in_ready", i), in_ready, tbl[i].e_ir);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), out_valid, tbl[i].e_ov);
      chk($sformatf("v%0d_out_data", i), out_data, tbl[i].e_od);
      chk($sformatf("v%0d_occupancy", i), occupancy, tbl[i].e_occ);
      chk($sformatf("v%0d_ch_valid", i), ch_valid, tbl[i].e_chv);
      chk($sformatf("v%0d_ch_data", i), ch_data, tbl[i].e_chd);
    end
    exp_cap = 4;
    chk("tbl_cap_count", cap_count, 16'(exp_cap));

    // back-to-back 1..8 with three stalled cycles after the first output
    got = 0; nw = 1; ch_en = '0; bypass = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      in_valid = (nw <= 8); in_data = 8'(nw); out_ready = !(c >= 7 && c <= 9);
      #1;
      chk($sformatf("s35_in_ready_c%0d", c), in_ready, (c >= 7 && c <= 9) ? 1'b0 : 1'b1);
      if (out_valid && out_ready) begin
        got++;
        chk($sformatf("s35_order_%0d", got), out_data, 64'(got));
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) nw++;
    end
    #1;
    in_valid = 0; out_ready = 1;
    chk("s35_out_count", 64'(got), 8);
    chk("s35_in_count", 64'(nw), 9);
    chk("s35_occupancy", occupancy, 0);
    exp_cap += 8;
    chk("s35_cap_count", cap_count, 16'(exp_cap));

    // three words in flight, then chain->bypass drain
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      in_valid = (k != 3); in_data = (k < 3) ? 8'(8'h21 + k) : 8'h44; bypass = (k >= 3);
      #1;
      chk($sformatf("s37_in_ready_k%0d", k), in_ready, 64'(e_ir37[k]));
      @(posedge clk);
      #1;
      chk($sformatf("s37_out_valid_k%0d", k), out_valid, 64'(e_ov37[k]));
      chk($sformatf("s37_out_data_k%0d", k), out_data, 64'(e_od37[k]));
      chk($sformatf("s37_occupancy_k%0d", k), occupancy, 64'(e_occ37[k]));
    end
    @(negedge clk); in_valid = 0;
    @(posedge clk); #1;
    chk("s37_drained", occupancy, 0);
    @(negedge clk); bypass = 0;
    @(posedge clk); #1;
    exp_cap += 4;
    chk("s37_cap_count", cap_count, 16'(exp_cap));

    // flush with four words in flight and a coincident valid input
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); in_valid = 1; in_data = 8'(8'h50 + k);
      #1 chk($sformatf("s38_in_ready_k%0d", k), in_ready, 1);
      @(posedge clk);
    end
    exp_cap += 4;
    @(negedge clk);
    chk("s38_occ_before", occupancy, 4);
    in_data = 8'h99; flush = 1;
    #1 chk("s38_in_ready_flush", in_ready, 0);
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    chk("s38_occupancy", occupancy, 0);
    chk("s38_out_valid", out_valid, 0);
    chk("s38_out_data", out_data, 8'h44);
    chk("s38_cap_count", cap_count, 16'(exp_cap));
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("s38_discard_c%0d", k), out_valid, 0);
    end
    chk("s38_in_ready_after", in_ready, 1);

    // cap_count wrap, then asynchronous reset mid-stream
    @(negedge clk);
    ch_en = 3'b111; in_data = 8'hC3; in_valid = 1;
    repeat (65535 - exp_cap) @(posedge clk);
    #1 in_valid = 0;
    chk("s39_cap_ffff", cap_count, 16'hFFFF);
    @(negedge clk); in_valid = 1; in_data = 8'h3C;
    @(posedge clk); #1 in_valid = 0;
    chk("s39_cap_wrap", cap_count, 16'h0000);
    chk("s39_ch_data", ch_data, 24'h3C3C3C);
    chk("s39_ch_valid", ch_valid, 3'b111);
    @(negedge clk); in_valid = 1; in_data = 8'hE1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("s39_rst_out_valid", out_valid, 0);
    chk("s39_rst_out_data", out_data, 0);
    chk("s39_rst_occupancy", occupancy, 0);
    chk("s39_rst_cap_count", cap_count, 0);
    chk("s39_rst_ch_valid", ch_valid, 0);
    chk("s39_rst_ch_data", ch_data, 0);
    chk("s39_rst_in_ready", in_ready, 1);
    in_valid = 0; ch_en = '0;
    @(negedge clk); rst_n = 1'b1;

    // first accept after reset behaves as from empty
    @(negedge clk); in_valid = 1; in_data = 8'h5A;
    #1 chk("s33_in_ready", in_ready, 1);
    @(posedge clk); #1 in_valid = 0;
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("s33_out_valid_c%0d", k), out_valid, (k == 6) ? 1'b1 : 1'b0);
      chk($sformatf("s33_out_data_c%0d", k), out_data, (k >= 6) ? 8'h5A : 8'h00);
      chk($sformatf("s33_occupancy_c%0d", k), occupancy, (k <= 6) ? 1 : 0);
      @(posedge clk); #1;
    end
    chk("s33_cap_count", cap_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
